// File: rtl/gshare_resolver.sv
// rtl/gshare_resolver.sv - in-order resolution queue for gshare predictions
//
// Holds every in-flight prediction {pc, bht index, ghr snapshot, predicted
// direction} in a circular buffer and retires the oldest one when execute
// reports the real outcome. Each retire emits a one-cycle BHT update; a
// wrong prediction also emits a mispredict pulse with the corrected GHR,
// empties the queue and spends one RECOVER cycle refusing traffic.
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   pred_valid/pred_ready    prediction handshake from the predictor
//   pred_pc/index/ghr/taken  prediction payload (pc kept for trace only)
//   res_valid/res_ready      resolution handshake from execute (oldest only)
//   res_taken                actual branch outcome
//   upd_valid/index/taken    registered BHT counter-update command
//   mispredict, restore_ghr  registered misprediction pulse and GHR restore
//   head_pc                  pc of the oldest entry, 0 when empty
//   count                    current occupancy (0..DEPTH)
module gshare_resolver #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 8,
  parameter int HIST_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  output logic                       pred_ready,
  input  logic [PC_W-1:0]            pred_pc,
  input  logic [HIST_W-1:0]          pred_index,
  input  logic [HIST_W-1:0]          pred_ghr,
  input  logic                       pred_taken,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic                       res_taken,
  output logic                       upd_valid,
  output logic [HIST_W-1:0]          upd_index,
  output logic                       upd_taken,
  output logic                       mispredict,
  output logic [HIST_W-1:0]          restore_ghr,
  output logic [PC_W-1:0]            head_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Entry storage; only head/tail/count need reset since empty slots are
  // never observed (head_pc is masked when the queue is empty).
  logic [PC_W-1:0]   q_pc    [DEPTH];
  logic [HIST_W-1:0] q_index [DEPTH];
  logic [HIST_W-1:0] q_ghr   [DEPTH];
  logic              q_taken [DEPTH];

  logic enq;
  logic ret;
  logic miss;

  assign pred_ready = (state == NORMAL) && (count < FULL_CNT);
  assign res_ready  = (state == NORMAL) && (count != '0);

  assign enq  = pred_valid && pred_ready;
  assign ret  = res_valid && res_ready;
  assign miss = ret && (q_taken[head] != res_taken);

  assign head_pc = (count == '0) ? '0 : q_pc[head];

  // A write during a mispredicting retire lands in a slot that the flush
  // immediately abandons, so the wrong-path entry is dropped for free.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[tail]    <= pred_pc;
      q_index[tail] <= pred_index;
      q_ghr[tail]   <= pred_ghr;
      q_taken[tail] <= pred_taken;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= NORMAL;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      upd_valid   <= 1'b0;
      upd_index   <= '0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      restore_ghr <= '0;
    end else begin
      upd_valid   <= ret;
      upd_index   <= ret ? q_index[head] : '0;
      upd_taken   <= ret && res_taken;
      mispredict  <= miss;
      // Corrected history: snapshot shifted left with the real outcome in bit 0.
      restore_ghr <= miss ? {q_ghr[head][HIST_W-2:0], res_taken} : '0;

      case (state)
        NORMAL: begin
          if (miss) begin
            state <= RECOVER;
            head  <= '0;
            tail  <= '0;
            count <= '0;
          end else begin
            if (enq) tail <= tail + 1'b1;
            if (ret) head <= head + 1'b1;
            if (enq && !ret)
              count <= count + 1'b1;
            else if (!enq && ret)
              count <= count - 1'b1;
          end
        end
        RECOVER: state <= NORMAL;
        default: state <= NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_gshare_resolver.sv
// tb/tb_gshare_resolver.sv - self-checking bench for gshare_resolver
module tb_gshare_resolver;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 8;
  localparam int HIST_W = 4;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset;
  logic              pred_valid;
  logic              pred_ready;
  logic [PC_W-1:0]   pred_pc;
  logic [HIST_W-1:0] pred_index;
  logic [HIST_W-1:0] pred_ghr;
  logic              pred_taken;
  logic              res_valid;
  logic              res_ready;
  logic              res_taken;
  logic              upd_valid;
  logic [HIST_W-1:0] upd_index;
  logic              upd_taken;
  logic              mispredict;
  logic [HIST_W-1:0] restore_ghr;
  logic [PC_W-1:0]   head_pc;
  logic [CNT_W-1:0]  count;

  gshare_resolver #(.DEPTH(DEPTH), .PC_W(PC_W), .HIST_W(HIST_W)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_index(pred_index), .pred_ghr(pred_ghr), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .mispredict(mispredict), .restore_ghr(restore_ghr),
    .head_pc(head_pc), .count(count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic pv; logic [PC_W-1:0] pc; logic [HIST_W-1:0] idx; logic [HIST_W-1:0] ghr; logic ptk;
    logic rv; logic rtk;
    logic e_pr; logic e_rr; logic e_uv; logic [HIST_W-1:0] e_ui; logic e_ut;
    logic e_mis; logic [HIST_W-1:0] e_rg; int e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic pv, logic [PC_W-1:0] pc, logic [HIST_W-1:0] idx,
                              logic [HIST_W-1:0] ghr, logic ptk, logic rv, logic rtk,
                              logic e_pr, logic e_rr, logic e_uv, logic [HIST_W-1:0] e_ui,
                              logic e_ut, logic e_mis, logic [HIST_W-1:0] e_rg, int e_cnt);
    vec_t v;
    v.pv = pv; v.pc = pc; v.idx = idx; v.ghr = ghr; v.ptk = ptk; v.rv = rv; v.rtk = rtk;
    v.e_pr = e_pr; v.e_rr = e_rr; v.e_uv = e_uv; v.e_ui = e_ui; v.e_ut = e_ut;
    v.e_mis = e_mis; v.e_rg = e_rg; v.e_cnt = e_cnt;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [PC_W-1:0] pc; logic [HIST_W-1:0] idx; logic [HIST_W-1:0] ghr; logic tk;
  } ent_t;

  ent_t              mq[$];
  bit                m_recover = 1'b0;
  logic              m_uv = 1'b0;
  logic              m_ut = 1'b0;
  logic              m_mis = 1'b0;
  logic [HIST_W-1:0] m_ui = '0;
  logic [HIST_W-1:0] m_rg = '0;

  function automatic bit m_pr();
    return !m_recover && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_rr();
    return !m_recover && (mq.size() != 0);
  endfunction

  task automatic model_clear();
    mq.delete();
    m_recover = 1'b0;
    m_uv = 1'b0; m_ut = 1'b0; m_mis = 1'b0; m_ui = '0; m_rg = '0;
  endtask

  task automatic model_step(input logic pv, input logic [PC_W-1:0] pc, input logic [HIST_W-1:0] idx,
                            input logic [HIST_W-1:0] ghr, input logic ptk,
                            input logic rv, input logic rtk);
    bit   enq;
    bit   ret;
    bit   mis;
    ent_t h;
    ent_t n;
    enq = pv && m_pr();
    ret = rv && m_rr();
    mis = 1'b0;
    m_uv = ret; m_ui = '0; m_ut = 1'b0; m_rg = '0;
    if (ret) begin
      h = mq.pop_front();
      m_ui = h.idx;
      m_ut = rtk;
      mis = (h.tk != rtk);
      if (mis) m_rg = HIST_W'((int'(h.ghr) * 2 + int'(rtk)) % (1 << HIST_W));
    end
    m_mis = mis;
    if (mis) begin
      mq.delete();
      m_recover = 1'b1;
    end else begin
      m_recover = 1'b0;
      if (enq) begin
        n.pc = pc; n.idx = idx; n.ghr = ghr; n.tk = ptk;
        mq.push_back(n);
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [PC_W-1:0] exp_pc;
    exp_pc = (mq.size() != 0) ? mq[0].pc : '0;
    chk({tag, ".upd_valid"}, 32'(upd_valid), 32'(m_uv));
    if (m_uv) begin
      chk({tag, ".upd_index"}, 32'(upd_index), 32'(m_ui));
      chk({tag, ".upd_taken"}, 32'(upd_taken), 32'(m_ut));
    end
    chk({tag, ".mispredict"}, 32'(mispredict), 32'(m_mis));
    if (m_mis) chk({tag, ".restore_ghr"}, 32'(restore_ghr), 32'(m_rg));
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".head_pc"}, 32'(head_pc), 32'(exp_pc));
  endtask

  task automatic drive(input logic pv, input logic [PC_W-1:0] pc, input logic [HIST_W-1:0] idx,
                       input logic [HIST_W-1:0] ghr, input logic ptk, input logic rv, input logic rtk);
    pred_valid = pv; pred_pc = pc; pred_index = idx; pred_ghr = ghr; pred_taken = ptk;
    res_valid = rv; res_taken = rtk;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".pred_ready"}, 32'(pred_ready), 32'd1);
    chk({tag, ".res_ready"}, 32'(res_ready), 32'd0);
    chk({tag, ".upd_valid"}, 32'(upd_valid), 32'd0);
    chk({tag, ".upd_index"}, 32'(upd_index), 32'd0);
    chk({tag, ".upd_taken"}, 32'(upd_taken), 32'd0);
    chk({tag, ".mispredict"}, 32'(mispredict), 32'd0);
    chk({tag, ".restore_ghr"}, 32'(restore_ghr), 32'd0);
    chk({tag, ".head_pc"}, 32'(head_pc), 32'd0);
  endtask

  initial begin
    vec_t v;

    // correct prediction
    tbl.push_back(mk(1, 8'h10,  5, 4'b0011, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0,       1));
    tbl.push_back(mk(0, 8'h00,  0, 4'b0000, 0, 1, 1,  1, 1,  1, 5, 1, 0, 0,       0));
    // fill to DEPTH, fifth prediction ignored
    tbl.push_back(mk(1, 8'h21,  1, 4'b0000, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0,       1));
    tbl.push_back(mk(1, 8'h22,  2, 4'b0000, 1, 0, 0,  1, 1,  0, 0, 0, 0, 0,       2));
    tbl.push_back(mk(1, 8'h23,  3, 4'b0000, 1, 0, 0,  1, 1,  0, 0, 0, 0, 0,       3));
    tbl.push_back(mk(1, 8'h24,  4, 4'b0000, 1, 0, 0,  1, 1,  0, 0, 0, 0, 0,       4));
    tbl.push_back(mk(1, 8'h25,  9, 4'b0000, 1, 0, 0,  0, 1,  0, 0, 0, 0, 0,       4));
    tbl.push_back(mk(0, 8'h00,  0, 4'b0000, 0, 1, 1,  0, 1,  1, 1, 1, 0, 0,       3));
    tbl.push_back(mk(0, 8'h00,  0, 4'b0000, 0, 1, 1,  1, 1,  1, 2, 1, 0, 0,       2));
    tbl.push_back(mk(0, 8'h00,  0, 4'b0000, 0, 1, 1,  1, 1,  1, 3, 1, 0, 0,       1));
    tbl.push_back(mk(0, 8'h00,  0, 4'b0000, 0, 1, 1,  1, 1,  1, 4, 1, 0, 0,       0));
    // six more across the pointer wrap
    tbl.push_back(mk(1, 8'h36,  6, 4'b0000, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0,       1));
    tbl.push_back(mk(1, 8'h37,  7, 4'b0000, 1, 0, 0,  1, 1,  0, 0, 0, 0, 0,       2));
    tbl.push_back(mk(1, 8'h38,  8, 4'b0000, 1, 0, 0,  1, 1,  0, 0, 0, 0, 0,       3));
    tbl.push_back(mk(1, 8'h39,  9, 4'b0000, 1, 1, 1,  1, 1,  1, 6, 1, 0, 0,       3));
    tbl.push_back(mk(1, 8'h3a, 10, 4'b0000, 1, 1, 1,  1, 1,  1, 7, 1, 0, 0,       3));
    tbl.push_back(mk(1, 8'h3b, 11, 4'b0000, 1, 1, 1,  1, 1,  1, 8, 1, 0, 0,       3));
    tbl.push_back(mk(0, 8'h00,  0, 4'b0000, 0, 1, 1,  1, 1,  1, 9, 1, 0, 0,       2));
    tbl.push_back(mk(0, 8'h00,  0, 4'b0000, 0, 1, 1,  1, 1,  1, 10, 1, 0, 0,      1));
    tbl.push_back(mk(0, 8'h00,  0, 4'b0000, 0, 1, 1,  1, 1,  1, 11, 1, 0, 0,      0));
    // mispredict flush of A, B, C
    tbl.push_back(mk(1, 8'ha0,  3, 4'b1010, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0,       1));
    tbl.push_back(mk(1, 8'hb0, 12, 4'b0000, 0, 0, 0,  1, 1,  0, 0, 0, 0, 0,       2));
    tbl.push_back(mk(1, 8'hc0, 13, 4'b0000, 1, 0, 0,  1, 1,  0, 0, 0, 0, 0,       3));
    tbl.push_back(mk(0, 8'h00,  0, 4'b0000, 0, 1, 0,  1, 1,  1, 3, 0, 1, 4'b0100, 0));
    tbl.push_back(mk(1, 8'hd0, 14, 4'b0000, 1, 1, 1,  0, 0,  0, 0, 0, 0, 0,       0));
    tbl.push_back(mk(0, 8'h00,  0, 4'b0000, 0, 0, 0,  1, 0,  0, 0, 0, 0, 0,       0));
    // simultaneous enqueue with correct, then mispredicting, retire at count=2
    tbl.push_back(mk(1, 8'h51,  1, 4'b0000, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0,       1));
    tbl.push_back(mk(1, 8'h52,  2, 4'b0110, 0, 0, 0,  1, 1,  0, 0, 0, 0, 0,       2));
    tbl.push_back(mk(1, 8'h53,  3, 4'b0000, 1, 1, 1,  1, 1,  1, 1, 1, 0, 0,       2));
    tbl.push_back(mk(1, 8'h54,  4, 4'b0000, 1, 1, 1,  1, 1,  1, 2, 1, 1, 4'b1101, 0));
    tbl.push_back(mk(0, 8'h00,  0, 4'b0000, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0,       0));
    tbl.push_back(mk(0, 8'h00,  0, 4'b0000, 0, 1, 1,  1, 0,  0, 0, 0, 0, 0,       0));

    // reset held with pred_valid high
    reset = 1'b1;
    drive(1, 8'hff, 4'hf, 4'hf, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_hold");
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("rst_release");
    @(posedge clk);
    #1;
    check_reset_state("rst_idle");

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.pv, v.pc, v.idx, v.ghr, v.ptk, v.rv, v.rtk);
      chk($sformatf("v%0d.pred_ready", i), 32'(pred_ready), 32'(v.e_pr));
      chk($sformatf("v%0d.res_ready", i), 32'(res_ready), 32'(v.e_rr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.upd_valid", i), 32'(upd_valid), 32'(v.e_uv));
      if (v.e_uv) begin
        chk($sformatf("v%0d.upd_index", i), 32'(upd_index), 32'(v.e_ui));
        chk($sformatf("v%0d.upd_taken", i), 32'(upd_taken), 32'(v.e_ut));
      end
      chk($sformatf("v%0d.mispredict", i), 32'(mispredict), 32'(v.e_mis));
      if (v.e_mis) chk($sformatf("v%0d.restore_ghr", i), 32'(restore_ghr), 32'(v.e_rg));
      chk($sformatf("v%0d.count", i), 32'(count), 32'(v.e_cnt));
    end

    // async reset mid-flight with an update pulse pending
    for (int i = 0; i < 4; i++) begin
      drive(1, PC_W'(8'h60 + i), HIST_W'(i), 4'h0, 1, 0, 0);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    @(posedge clk);
    #1;
    chk("arst.pre_count", 32'(count), 32'd3);
    chk("arst.pre_upd_valid", 32'(upd_valid), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("arst.async");
    @(posedge clk);
    #1;
    check_reset_state("arst.held");
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 1);
    #1;
    chk("arst.res_ready", 32'(res_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("arst.no_update", 32'(upd_valid), 32'd0);
    chk("arst.count", 32'(count), 32'd0);

    // randomized traffic against the queue model
    model_clear();
    for (int c = 0; c < 3000; c++) begin
      logic              pv;
      logic              rv;
      logic              rtk;
      logic              ptk;
      logic [PC_W-1:0]   pc;
      logic [HIST_W-1:0] idx;
      logic [HIST_W-1:0] ghr;
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1;
        #1;
        model_clear();
        check_model($sformatf("r%0d.arst", c));
        @(posedge clk);
        #1;
        check_model($sformatf("r%0d.arst_held", c));
        reset = 1'b0;
        continue;
      end
      pv  = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 9) < 6);
      pc  = PC_W'($urandom);
      idx = HIST_W'($urandom);
      ghr = HIST_W'($urandom);
      ptk = 1'($urandom_range(0, 1));
      if (mq.size() != 0 && $urandom_range(0, 7) != 0)
        rtk = mq[0].tk;
      else
        rtk = 1'($urandom_range(0, 1));
      drive(pv, pc, idx, ghr, ptk, rv, rtk);
      chk($sformatf("r%0d.pred_ready", c), 32'(pred_ready), 32'(m_pr()));
      chk($sformatf("r%0d.res_ready", c), 32'(res_ready), 32'(m_rr()));
      model_step(pv, pc, idx, ghr, ptk, rv, rtk);
      @(posedge clk);
      #1;
      check_model($sformatf("r%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
